// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register-file read path.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 16;
    localparam int DEF_IDXW  = 4;
    localparam int ZERO_REG  = 0;

    typedef struct packed {
        logic [DEF_IDXW-1:0]  idx;
        logic [DEF_WIDTH-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/regfile_read_ctrl_rsp_fifo.sv
// Response buffer: circular FIFO with wrap-around pointers and an occupancy counter.
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 20,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/regfile_read_ctrl.sv
// Read-port controller: request stage S1, one-hot wordline drive, write bypass,
// and a buffered response channel.
module regfile_read_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IDXW  = DEF_IDXW,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDXW-1:0]  req_idx,
    output logic [NREGS-1:0] rden,
    input  logic [WIDTH-1:0] bitline,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [IDXW-1:0]  rsp_idx
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic            s1_valid;
    logic [IDXW-1:0] s1_idx;
    logic            s1_is_zero;
    logic            accept;
    logic            pop;
    logic [CW-1:0]   occ;
    logic [CW:0]     level;
    entry_t          push_entry;
    entry_t          head_entry;

    assign accept     = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign s1_is_zero = (s1_idx == IDXW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_idx <= req_idx;
        end
    end

    always_comb begin
        rden = '0;
        if (s1_valid && !s1_is_zero) rden[s1_idx] = 1'b1;
    end

    // R0 is never driven onto the bus; a write landing on the S1 edge must win over the stale array value
    always_comb begin
        push_entry.idx = s1_idx;
        if (s1_is_zero)
            push_entry.data = '0;
        else if (wr_en && (wr_idx == s1_idx))
            push_entry.data = wr_data;
        else
            push_entry.data = bitline;
    end

    rsp_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_valid),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (occ)
    );

    assign level     = (CW + 1)'(occ) + (CW + 1)'(s1_valid) - (CW + 1)'(pop);
    assign req_ready = rst_n && (level < (CW + 1)'(DEPTH));

    assign rsp_valid = (occ != '0);
    assign rsp_data  = rsp_valid ? head_entry.data : '0;
    assign rsp_idx   = rsp_valid ? head_entry.idx  : '0;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Bench for regfile_read_ctrl: array model on the bitline bus, a read-result
// scoreboard checked every cycle, and directed literal checks.
module tb_regfile_read_ctrl;
    import regfile_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREGS = 16;
    localparam int IDXW  = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [IDXW-1:0]  req_idx;
    logic [NREGS-1:0] rden;
    logic [WIDTH-1:0] bitline;
    logic             wr_en;
    logic [IDXW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [IDXW-1:0]  rsp_idx;

    int checks = 0;
    int errors = 0;

    regfile_read_ctrl #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .IDXW  (IDXW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .rden      (rden),
        .bitline   (bitline),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_idx   (rsp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-cell array: updates at the edge, drives the bus only for a selected row
    logic [WIDTH-1:0] regs  [NREGS];
    logic [WIDTH-1:0] mregs [NREGS];

    always @(posedge clk) if (wr_en) regs[wr_idx] <= wr_data;

    always_comb begin
        bitline = 'z;
        for (int i = 0; i < NREGS; i++)
            if (rden[i]) bitline = regs[i];
    end

    // Model: a read returns the register's content as it stands right after its S1 edge
    logic            m_s1_valid = 1'b0;
    logic [IDXW-1:0] m_s1_idx   = '0;
    rsp_entry_t      exp_q[$];
    logic [IDXW-1:0] popped_q[$];

    always @(posedge clk) begin
        rsp_entry_t e;
        if (!rst_n) begin
            m_s1_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                popped_q.push_back(rsp_idx);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (wr_en) mregs[wr_idx] = wr_data;
            if (m_s1_valid) begin
                e.idx  = m_s1_idx;
                e.data = (m_s1_idx == 0) ? 16'h0000 : mregs[m_s1_idx];
                exp_q.push_back(e);
            end
            m_s1_valid = req_valid && req_ready;
            m_s1_idx   = req_idx;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NREGS-1:0] er;
        if (rst_n) begin
            er = '0;
            if (m_s1_valid && m_s1_idx != 0) er[m_s1_idx] = 1'b1;
            check("model_rden", rden, er);
            check("model_rsp_valid", rsp_valid, exp_q.size() != 0);
            if (rsp_valid && exp_q.size() != 0) begin
                check("model_rsp_data", rsp_data, exp_q[0].data);
                check("model_rsp_idx", rsp_idx, exp_q[0].idx);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge
    task automatic send(input logic [IDXW-1:0] idx, output int stalls);
        logic rdy;
        stalls    = 0;
        req_valid = 1'b1;
        req_idx   = idx;
        for (int n = 0; n < 50; n++) begin
            #1 rdy = req_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) return;
            stalls++;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int st;
        int total;
        int k;
        logic rdy;
        logic [IDXW-1:0] list [10];

        for (int i = 0; i < NREGS; i++) begin
            regs[i]  = {4'(i), 12'h0C3};
            mregs[i] = {4'(i), 12'h0C3};
        end
        regs[5] = 16'h1234; mregs[5] = 16'h1234;
        regs[3] = 16'h00AA; mregs[3] = 16'h00AA;

        rst_n = 1'b0; req_valid = 1'b0; req_idx = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rsp_ready = 1'b1;
        #3;
        check("reset_rden", rden, 16'h0000);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 16'h0000);
        check("reset_rsp_idx", rsp_idx, 4'h0);
        check("reset_req_ready", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("release_req_ready", req_ready, 1'b1);
        @(negedge clk);

        // Single read of R5
        send(4'd5, st);
        req_valid = 1'b0;
        check("r5_rden_s1", rden, 16'h0020);
        @(negedge clk);
        check("r5_rden_after", rden, 16'h0000);
        check("r5_rsp_valid", rsp_valid, 1'b1);
        check("r5_rsp_data", rsp_data, 16'h1234);
        check("r5_rsp_idx", rsp_idx, 4'd5);
        @(negedge clk);
        check("r5_popped", rsp_valid, 1'b0);

        // R0 with a floating bus
        send(4'd0, st);
        req_valid = 1'b0;
        check("r0_rden", rden, 16'h0000);
        @(negedge clk);
        check("r0_rsp_data", rsp_data, 16'h0000);
        check("r0_rsp_valid", rsp_valid, 1'b1);
        @(negedge clk);

        // Bypass: write R3 during its S1 cycle
        send(4'd3, st);
        req_valid = 1'b0;
        wr_en = 1'b1; wr_idx = 4'd3; wr_data = 16'hBEEF;
        @(negedge clk);
        wr_en = 1'b0;
        check("bypass_r3", rsp_data, 16'hBEEF);
        @(negedge clk);

        // Write one cycle before S1 lands in the array; an unrelated S1 write does not bypass
        wr_en = 1'b1; wr_idx = 4'd3; wr_data = 16'h00AA;
        send(4'd3, st);
        req_valid = 1'b0;
        wr_idx = 4'd4; wr_data = 16'h7777;
        @(negedge clk);
        wr_en = 1'b0;
        check("no_bypass_r3", rsp_data, 16'h00AA);
        @(negedge clk);

        // Backpressure: two acceptances fill S1 plus the buffer
        rsp_ready = 1'b0;
        popped_q.delete();
        k = 0;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_idx = 4'(k + 1);
            #1 rdy = req_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) k++;
        end
        check("stall_accepts", k, 2);
        #1 check("stall_req_ready", req_ready, 1'b0);
        rsp_ready = 1'b1;
        while (k < 4) begin
            send(4'(k + 1), st);
            k++;
        end
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("stream_count", popped_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < popped_q.size()) check("stream_order", popped_q[i], i + 1);

        // Continuous reads with interleaved writes, wrapping the buffer several times
        popped_q.delete();
        total = 0;
        for (int i = 0; i < 10; i++) list[i] = 4'((i * 3 + 1) % 16);
        for (int i = 0; i < 10; i++) begin
            wr_en   = (i % 3 != 2);
            wr_idx  = (i % 2 == 0) ? list[(i + 9) % 10] : list[(i + 1) % 10];
            wr_data = 16'hA000 + 16'(i);
            send(list[i], st);
            total += st;
        end
        req_valid = 1'b0;
        wr_en = 1'b0;
        repeat (4) @(negedge clk);
        check("cont_stalls", total, 0);
        check("cont_count", popped_q.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < popped_q.size()) check("cont_order", popped_q[i], list[i]);

        // Asynchronous reset with one read buffered and one in S1
        rsp_ready = 1'b0;
        popped_q.delete();
        send(4'd2, st);
        send(4'd6, st);
        req_valid = 1'b0;
        #1;
        check("pre_rst_rsp_valid", rsp_valid, 1'b1);
        check("pre_rst_rden", rden, 16'h0040);
        #1 rst_n = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 1'b0);
        check("async_rden", rden, 16'h0000);
        check("async_rsp_data", rsp_data, 16'h0000);
        check("async_req_ready", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_stale", popped_q.size(), 0);
        check("post_rst_rsp_valid", rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
